// File: rtl/lock_ctrl_if.sv
// -----------------------------------------------------------------------------
// lock_ctrl_if
//   Signal bundle between the doorlock controller and its surroundings
//   (keypad buttons, entry buffer / password memory comparators and strobes).
//
//   master modport : the controller (lock_ctrl_fsm) - samples buttons and
//                    comparator results, drives strobes, status and seed.
//   slave modport  : the environment - drives buttons and comparator results,
//                    observes everything the controller produces.
//
//   Signals
//     confirm_in   button level, action on release
//     shuffle_in   button level, action on release
//     input_valid  one-cycle pulse, keypad digit ready
//     same         entry buffer equals stored password
//     master_same  entry buffer equals master code
//     shuffle_init one-cycle pulse, keypad shuffle start
//     seed         LFSR snapshot taken with shuffle_init
//     decision     high throughout OPEN
//     mem_sl       password memory shift-load pulse
//     buff_sl      entry buffer shift-load pulse
//     mem_rst      password memory clear pulse
//     buff_rst     entry buffer clear pulse
//     alarm        high throughout LOCKOUT
//     fail_cnt     consecutive failed challenges
//     state        controller state encoding
// -----------------------------------------------------------------------------
interface lock_ctrl_if #(
  parameter int SEED_W = 32,
  parameter int FAIL_W = 2
);

  logic              confirm_in;
  logic              shuffle_in;
  logic              input_valid;
  logic              same;
  logic              master_same;

  logic              shuffle_init;
  logic [SEED_W-1:0] seed;
  logic              decision;
  logic              mem_sl;
  logic              buff_sl;
  logic              mem_rst;
  logic              buff_rst;
  logic              alarm;
  logic [FAIL_W-1:0] fail_cnt;
  logic [2:0]        state;

  modport master (
    input  confirm_in, shuffle_in, input_valid, same, master_same,
    output shuffle_init, seed, decision, mem_sl, buff_sl, mem_rst, buff_rst,
           alarm, fail_cnt, state
  );

  modport slave (
    output confirm_in, shuffle_in, input_valid, same, master_same,
    input  shuffle_init, seed, decision, mem_sl, buff_sl, mem_rst, buff_rst,
           alarm, fail_cnt, state
  );

endinterface

// File: rtl/lock_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// lock_ctrl_fsm
//   Doorlock master controller. Sequences password set, confirm, lock,
//   challenge, keypad shuffle, timed open and brute-force lockout. Drives the
//   password memory / entry buffer strobes and holds a free-running Galois
//   LFSR whose snapshot seeds the keypad shuffler.
//
//   Ports
//     clk  system clock, everything on posedge
//     rst  synchronous active-high reset
//     bus  lock_ctrl_if.master - buttons, comparators, strobes and status
//
//   Timing
//     Every output is a register. An event sampled at edge k shows up on the
//     outputs from edge k to edge k+1. Button actions fire on release
//     (previous level 1, current level 0).
//
//   State encoding
//     IDLE=0 SET=1 CONFIRM=2 LOCKED=3 CHALLENGE=4 SHUFFLE=5 OPEN=6 LOCKOUT=7
// -----------------------------------------------------------------------------
module lock_ctrl_fsm #(
  parameter int                PSW_LEN     = 8,
  parameter int                MIN_LEN     = 4,
  parameter int                MAX_FAIL    = 3,
  parameter int                SHUFFLE_CYC = 15,
  parameter int                OPEN_CYC    = 100,
  parameter int                LOCKOUT_CYC = 1000,
  parameter int                SEED_W      = 32,
  parameter logic [SEED_W-1:0] SEED_INIT   = SEED_W'(32'hACE12468),
  parameter logic [SEED_W-1:0] LFSR_TAPS   = SEED_W'(32'h80200003)
) (
  input  logic       clk,
  input  logic       rst,
  lock_ctrl_if.master bus
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int MC_W   = $clog2(PSW_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int T_MAX  = (SHUFFLE_CYC > OPEN_CYC)
                          ? ((SHUFFLE_CYC > LOCKOUT_CYC) ? SHUFFLE_CYC : LOCKOUT_CYC)
                          : ((OPEN_CYC    > LOCKOUT_CYC) ? OPEN_CYC    : LOCKOUT_CYC);
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [MC_W-1:0]   MC_FULL    = MC_W'(PSW_LEN);
  localparam logic [MC_W-1:0]   MC_MIN     = MC_W'(MIN_LEN);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
  localparam logic [TMR_W-1:0]  T_SHUFFLE  = TMR_W'(SHUFFLE_CYC - 1);
  localparam logic [TMR_W-1:0]  T_OPEN     = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0]  T_LOCKOUT  = TMR_W'(LOCKOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SET       = 3'd1,
    ST_CONFIRM   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_CHALLENGE = 3'd4,
    ST_SHUFFLE   = 3'd5,
    ST_OPEN      = 3'd6,
    ST_LOCKOUT   = 3'd7
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t              state_q,  state_d;
  state_t              ret_q,    ret_d;     // where SHUFFLE returns to
  logic [TMR_W-1:0]    tmr_q,    tmr_d;     // cycles spent in a timed state
  logic [MC_W-1:0]     mc_q,     mc_d;      // digits in password memory
  logic [MC_W-1:0]     bc_q,     bc_d;      // digits in entry buffer
  logic [FAIL_W-1:0]   fail_q,   fail_d;
  logic [SEED_W-1:0]   lfsr_q,   lfsr_d;
  logic                confirm_prev;
  logic                shuffle_prev;

  // Registered outputs
  logic                shuffle_init_q, shuffle_init_d;
  logic [SEED_W-1:0]   seed_q,         seed_d;
  logic                decision_q,     decision_d;
  logic                mem_sl_q,       mem_sl_d;
  logic                buff_sl_q,      buff_sl_d;
  logic                mem_rst_q,      mem_rst_d;
  logic                buff_rst_q,     buff_rst_d;
  logic                alarm_q,        alarm_d;

  // ---------------------------------------------------------------------------
  // Event decode
  //   Releases only count in the four interactive states; in SHUFFLE, OPEN and
  //   LOCKOUT they are dropped (the edge registers still track the buttons, so
  //   nothing is queued). Priority: shuffle > confirm > digit.
  // ---------------------------------------------------------------------------
  logic confirm_rel, shuffle_rel, interactive;
  logic shuffle_ev, confirm_ev, digit_ev;
  logic mc_full, bc_full, mc_ok, fail_last;

  assign confirm_rel = confirm_prev & ~bus.confirm_in;
  assign shuffle_rel = shuffle_prev & ~bus.shuffle_in;
  assign interactive = state_q inside {ST_SET, ST_CONFIRM, ST_LOCKED, ST_CHALLENGE};

  assign shuffle_ev  = interactive & shuffle_rel;
  assign confirm_ev  = interactive & confirm_rel & ~shuffle_rel;
  assign digit_ev    = interactive & bus.input_valid & ~shuffle_rel & ~confirm_rel;

  assign mc_full     = (mc_q == MC_FULL);
  assign bc_full     = (bc_q == MC_FULL);
  assign mc_ok       = (mc_q >= MC_MIN);
  // fail_q is always below MAX_FAIL outside LOCKOUT, so the increment fits.
  assign fail_last   = ((fail_q + FAIL_W'(1)) == FAIL_LIMIT);

  // ---------------------------------------------------------------------------
  // Next-state logic (state, timers, counters, LFSR)
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default at the
  // top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    tmr_d   = tmr_q;
    mc_d    = mc_q;
    bc_d    = bc_q;
    fail_d  = fail_q;

    // Galois LFSR, shifting right; free-running outside reset.
    lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    if (shuffle_ev) begin
      ret_d   = state_q;
      state_d = ST_SHUFFLE;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SET;

        ST_SET: begin
          if (confirm_ev) begin
            if (mc_ok) begin
              state_d = ST_CONFIRM;
              bc_d    = '0;
            end else begin
              mc_d    = '0;
            end
          end else if (digit_ev) begin
            // A digit past the last slot restarts the entry from scratch.
            mc_d = mc_full ? '0 : mc_q + MC_W'(1);
          end
        end

        ST_CONFIRM: begin
          if (confirm_ev) begin
            bc_d = '0;
            if (bus.same) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_SET;
              mc_d    = '0;
            end
          end else if (digit_ev) begin
            bc_d = bc_full ? '0 : bc_q + MC_W'(1);
          end
        end

        ST_LOCKED: begin
          if (confirm_ev) begin
            state_d = ST_CHALLENGE;
            bc_d    = '0;
          end
        end

        ST_CHALLENGE: begin
          if (confirm_ev) begin
            if (bus.same) begin
              state_d = ST_OPEN;
              fail_d  = '0;
              tmr_d   = '0;
            end else if (bus.master_same) begin
              // Master code: wipe the password and start over.
              state_d = ST_SET;
              mc_d    = '0;
              bc_d    = '0;
              fail_d  = '0;
            end else if (fail_last) begin
              state_d = ST_LOCKOUT;
              fail_d  = fail_q + FAIL_W'(1);
              tmr_d   = '0;
            end else begin
              state_d = ST_LOCKED;
              fail_d  = fail_q + FAIL_W'(1);
              bc_d    = '0;
            end
          end else if (digit_ev) begin
            bc_d = bc_full ? '0 : bc_q + MC_W'(1);
          end
        end

        // Digit counters are left untouched so entry resumes after the shuffle.
        ST_SHUFFLE: begin
          if (tmr_q == T_SHUFFLE) begin
            state_d = ret_q;
            tmr_d   = '0;
          end else begin
            tmr_d   = tmr_q + TMR_W'(1);
          end
        end

        ST_OPEN: begin
          if (tmr_q == T_OPEN) begin
            state_d = ST_LOCKED;
            tmr_d   = '0;
          end else begin
            tmr_d   = tmr_q + TMR_W'(1);
          end
        end

        ST_LOCKOUT: begin
          if (tmr_q == T_LOCKOUT) begin
            state_d = ST_LOCKED;
            tmr_d   = '0;
            fail_d  = '0;
          end else begin
            tmr_d   = tmr_q + TMR_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (values registered on the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    shuffle_init_d = 1'b0;
    seed_d         = seed_q;  // seed holds its last snapshot
    mem_sl_d       = 1'b0;
    buff_sl_d      = 1'b0;
    mem_rst_d      = 1'b0;
    buff_rst_d     = 1'b0;

    if (shuffle_ev) begin
      shuffle_init_d = 1'b1;
      seed_d         = lfsr_q;
    end else begin
      unique case (state_q)
        ST_SET: begin
          if (confirm_ev) begin
            buff_rst_d = mc_ok;
            mem_rst_d  = ~mc_ok;
          end else if (digit_ev) begin
            mem_sl_d   = ~mc_full;
            mem_rst_d  = mc_full;
          end
        end

        ST_CONFIRM: begin
          if (confirm_ev) begin
            buff_rst_d = 1'b1;
            mem_rst_d  = ~bus.same;
          end else if (digit_ev) begin
            buff_sl_d  = ~bc_full;
            buff_rst_d = bc_full;
          end
        end

        ST_LOCKED: begin
          if (confirm_ev) buff_rst_d = 1'b1;
        end

        ST_CHALLENGE: begin
          if (confirm_ev) begin
            if (!bus.same) begin
              if (bus.master_same) begin
                mem_rst_d  = 1'b1;
                buff_rst_d = 1'b1;
              end else begin
                // The lockout path leaves the buffer alone.
                buff_rst_d = ~fail_last;
              end
            end
          end else if (digit_ev) begin
            buff_sl_d  = ~bc_full;
            buff_rst_d = bc_full;
          end
        end

        default: ;
      endcase
    end

    decision_d = (state_d == ST_OPEN);
    alarm_d    = (state_d == ST_LOCKOUT);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ret_q          <= ST_IDLE;
      tmr_q          <= '0;
      mc_q           <= '0;
      bc_q           <= '0;
      fail_q         <= '0;
      lfsr_q         <= SEED_INIT;
      confirm_prev   <= 1'b0;
      shuffle_prev   <= 1'b0;
      shuffle_init_q <= 1'b0;
      seed_q         <= '0;
      decision_q     <= 1'b0;
      mem_sl_q       <= 1'b0;
      buff_sl_q      <= 1'b0;
      mem_rst_q      <= 1'b0;
      buff_rst_q     <= 1'b0;
      alarm_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ret_q          <= ret_d;
      tmr_q          <= tmr_d;
      mc_q           <= mc_d;
      bc_q           <= bc_d;
      fail_q         <= fail_d;
      lfsr_q         <= lfsr_d;
      confirm_prev   <= bus.confirm_in;
      shuffle_prev   <= bus.shuffle_in;
      shuffle_init_q <= shuffle_init_d;
      seed_q         <= seed_d;
      decision_q     <= decision_d;
      mem_sl_q       <= mem_sl_d;
      buff_sl_q      <= buff_sl_d;
      mem_rst_q      <= mem_rst_d;
      buff_rst_q     <= buff_rst_d;
      alarm_q        <= alarm_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.fail_cnt     = fail_q;
  assign bus.shuffle_init = shuffle_init_q;
  assign bus.seed         = seed_q;
  assign bus.decision     = decision_q;
  assign bus.mem_sl       = mem_sl_q;
  assign bus.buff_sl      = buff_sl_q;
  assign bus.mem_rst      = mem_rst_q;
  assign bus.buff_rst     = buff_rst_q;
  assign bus.alarm        = alarm_q;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_lock_ctrl_fsm
//   Directed bench for lock_ctrl_fsm with PSW_LEN=4, MIN_LEN=2, MAX_FAIL=2,
//   SHUFFLE_CYC=3, OPEN_CYC=4, LOCKOUT_CYC=6. Inputs change 1 time unit after
//   a rising edge; outputs are sampled at that same point, i.e. they show what
//   the edge just produced.
// -----------------------------------------------------------------------------
module tb_lock_ctrl_fsm;

  localparam logic [31:0] SEED_INIT = 32'hACE12468;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  lock_ctrl_if #(.SEED_W(32), .FAIL_W(2)) bus ();

  lock_ctrl_fsm #(
    .PSW_LEN(4), .MIN_LEN(2), .MAX_FAIL(2),
    .SHUFFLE_CYC(3), .OPEN_CYC(4), .LOCKOUT_CYC(6),
    .SEED_W(32), .SEED_INIT(SEED_INIT), .LFSR_TAPS(LFSR_TAPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Reference LFSR: Galois right shift with the feedback mask.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  logic [31:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED_INIT;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic digit();
    bus.input_valid = 1'b1;
    tick();
    bus.input_valid = 1'b0;
  endtask

  // Press then release; the release is sampled on the second edge.
  task automatic release_confirm();
    bus.confirm_in = 1'b1;
    tick();
    bus.confirm_in = 1'b0;
    tick();
  endtask

  // Returns the reference LFSR value present at the release edge.
  task automatic release_shuffle(output logic [31:0] pre);
    bus.shuffle_in = 1'b1;
    tick();
    bus.shuffle_in = 1'b0;
    pre = m_lfsr;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.confirm_in = 1'b0; bus.shuffle_in = 1'b0; bus.input_valid = 1'b0;
    bus.same = 1'b0; bus.master_same = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.state, bus.shuffle_init, bus.seed, bus.decision, bus.mem_sl, bus.buff_sl,
         bus.mem_rst, bus.buff_rst, bus.alarm, bus.fail_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs state=%0d seed=%h fail_cnt=%0d strobes=%b want all 0",
               bus.state, bus.seed, bus.fail_cnt,
               {bus.shuffle_init, bus.decision, bus.mem_sl, bus.buff_sl, bus.mem_rst, bus.buff_rst, bus.alarm});
    end
    rst = 1'b0;
    tick();
    total++;
    if ({bus.state, bus.mem_sl, bus.mem_rst, bus.buff_rst, bus.alarm, bus.decision} !== {3'd1, 5'b0}) begin
      bad++;
      $display("FAIL reset_to_set state=%0d strobes=%b want state=1 strobes=0",
               bus.state, {bus.mem_sl, bus.mem_rst, bus.buff_rst, bus.alarm, bus.decision});
    end
  endtask

  task automatic test_set_entry();
    for (int i = 1; i <= 5; i++) begin
      digit();
      total++;
      if ({bus.mem_sl, bus.mem_rst} !== ((i <= 4) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL set_digit_%0d sl/rst=%b want %b", i, {bus.mem_sl, bus.mem_rst},
                 (i <= 4) ? 2'b10 : 2'b01);
      end
    end
    release_confirm();
    total++;
    if ({bus.state, bus.mem_rst, bus.buff_rst} !== {3'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL set_short_confirm state=%0d mem_rst=%b buff_rst=%b want 1/1/0",
               bus.state, bus.mem_rst, bus.buff_rst);
    end
  endtask

  task automatic test_confirm();
    for (int i = 0; i < 3; i++) digit();
    total++;
    if (bus.mem_sl !== 1'b1) begin
      bad++;
      $display("FAIL set_third_digit mem_sl=%b want 1", bus.mem_sl);
    end
    release_confirm();
    total++;
    if ({bus.state, bus.buff_rst, bus.mem_rst} !== {3'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL to_confirm state=%0d buff_rst=%b mem_rst=%b want 2/1/0",
               bus.state, bus.buff_rst, bus.mem_rst);
    end
    for (int i = 0; i < 3; i++) digit();
    total++;
    if ({bus.buff_sl, bus.buff_rst} !== 2'b10) begin
      bad++;
      $display("FAIL confirm_digit sl/rst=%b want 10", {bus.buff_sl, bus.buff_rst});
    end
    release_confirm();
    total++;
    if ({bus.state, bus.mem_rst, bus.buff_rst} !== {3'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL confirm_mismatch state=%0d mem_rst=%b buff_rst=%b want 1/1/1",
               bus.state, bus.mem_rst, bus.buff_rst);
    end
    for (int i = 0; i < 3; i++) digit();
    release_confirm();
    for (int i = 0; i < 3; i++) digit();
    bus.same = 1'b1;
    release_confirm();
    bus.same = 1'b0;
    total++;
    if ({bus.state, bus.mem_rst, bus.buff_rst} !== {3'd3, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL confirm_match state=%0d mem_rst=%b buff_rst=%b want 3/0/1",
               bus.state, bus.mem_rst, bus.buff_rst);
    end
  endtask

  task automatic test_shuffle();
    logic [31:0] pre;
    release_confirm();
    total++;
    if ({bus.state, bus.buff_rst} !== {3'd4, 1'b1}) begin
      bad++;
      $display("FAIL to_challenge state=%0d buff_rst=%b want 4/1", bus.state, bus.buff_rst);
    end
    digit();
    digit();
    release_shuffle(pre);
    total++;
    if ({bus.state, bus.shuffle_init} !== {3'd5, 1'b1} || bus.seed !== pre) begin
      bad++;
      $display("FAIL shuffle_start state=%0d init=%b seed=%h want 5/1/%h",
               bus.state, bus.shuffle_init, bus.seed, pre);
    end
    tick();
    total++;
    if ({bus.state, bus.shuffle_init} !== {3'd5, 1'b0} || bus.seed !== pre) begin
      bad++;
      $display("FAIL shuffle_hold state=%0d init=%b seed=%h want 5/0/%h",
               bus.state, bus.shuffle_init, bus.seed, pre);
    end
    digit();
    total++;
    if ({bus.state, bus.buff_sl, bus.buff_rst} !== {3'd5, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL shuffle_ignores_digit state=%0d sl=%b rst=%b want 5/0/0",
               bus.state, bus.buff_sl, bus.buff_rst);
    end
    tick();
    total++;
    if (bus.state !== 3'd4) begin
      bad++;
      $display("FAIL shuffle_return state=%0d want 4", bus.state);
    end
    // bc resumes at 2: slots 3 and 4 load, the next digit overflows.
    for (int i = 0; i < 3; i++) begin
      digit();
      total++;
      if ({bus.buff_sl, bus.buff_rst} !== ((i < 2) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL resume_digit_%0d sl/rst=%b want %b", i, {bus.buff_sl, bus.buff_rst},
                 (i < 2) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_lockout();
    release_confirm();
    total++;
    if ({bus.state, bus.fail_cnt, bus.buff_rst} !== {3'd3, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL first_fail state=%0d fail_cnt=%0d buff_rst=%b want 3/1/1",
               bus.state, bus.fail_cnt, bus.buff_rst);
    end
    release_confirm();
    release_confirm();
    total++;
    if ({bus.state, bus.fail_cnt, bus.alarm, bus.buff_rst} !== {3'd7, 2'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL lockout_entry state=%0d fail_cnt=%0d alarm=%b buff_rst=%b want 7/2/1/0",
               bus.state, bus.fail_cnt, bus.alarm, bus.buff_rst);
    end
    for (int i = 1; i <= 5; i++) begin
      bus.confirm_in = (i == 2);
      tick();
      total++;
      if ({bus.state, bus.alarm} !== {3'd7, 1'b1}) begin
        bad++;
        $display("FAIL lockout_cycle_%0d state=%0d alarm=%b want 7/1", i + 1, bus.state, bus.alarm);
      end
    end
    tick();
    total++;
    if ({bus.state, bus.alarm, bus.fail_cnt} !== {3'd3, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL lockout_exit state=%0d alarm=%b fail_cnt=%0d want 3/0/0",
               bus.state, bus.alarm, bus.fail_cnt);
    end
  endtask

  task automatic test_priority_open();
    release_confirm();
    bus.same       = 1'b1;
    bus.shuffle_in = 1'b1;
    bus.confirm_in = 1'b1;
    tick();
    bus.shuffle_in = 1'b0;
    bus.confirm_in = 1'b0;
    tick();
    total++;
    if ({bus.state, bus.shuffle_init, bus.decision} !== {3'd5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL dual_release state=%0d init=%b decision=%b want 5/1/0",
               bus.state, bus.shuffle_init, bus.decision);
    end
    tick();
    tick();
    tick();
    total++;
    if ({bus.state, bus.decision} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL dual_return state=%0d decision=%b want 4/0", bus.state, bus.decision);
    end
    bus.same = 1'b0;
    release_confirm();
    release_confirm();
    bus.same = 1'b1;
    release_confirm();
    bus.same = 1'b0;
    total++;
    if ({bus.state, bus.decision, bus.fail_cnt} !== {3'd6, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL open_entry state=%0d decision=%b fail_cnt=%0d want 6/1/0",
               bus.state, bus.decision, bus.fail_cnt);
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      total++;
      if ({bus.state, bus.decision} !== {3'd6, 1'b1}) begin
        bad++;
        $display("FAIL open_cycle_%0d state=%0d decision=%b want 6/1", i, bus.state, bus.decision);
      end
    end
    tick();
    total++;
    if ({bus.state, bus.decision} !== {3'd3, 1'b0}) begin
      bad++;
      $display("FAIL open_exit state=%0d decision=%b want 3/0", bus.state, bus.decision);
    end
    release_confirm();
    bus.master_same = 1'b1;
    release_confirm();
    bus.master_same = 1'b0;
    total++;
    if ({bus.state, bus.mem_rst, bus.buff_rst, bus.fail_cnt} !== {3'd1, 1'b1, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL master_code state=%0d mem_rst=%b buff_rst=%b fail_cnt=%0d want 1/1/1/0",
               bus.state, bus.mem_rst, bus.buff_rst, bus.fail_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pre;
    digit();
    digit();
    release_confirm();
    rst = 1'b1;
    tick();
    total++;
    if ({bus.state, bus.seed, bus.fail_cnt, bus.buff_rst, bus.mem_rst} !== '0) begin
      bad++;
      $display("FAIL mid_reset state=%0d seed=%h fail_cnt=%0d want all 0",
               bus.state, bus.seed, bus.fail_cnt);
    end
    rst = 1'b0;
    tick();
    release_confirm();
    total++;
    if ({bus.state, bus.mem_rst} !== {3'd1, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_cleared state=%0d mem_rst=%b want 1/1", bus.state, bus.mem_rst);
    end
    release_shuffle(pre);
    total++;
    if ({bus.state, bus.shuffle_init} !== {3'd5, 1'b1} || bus.seed !== pre) begin
      bad++;
      $display("FAIL mid_reset_seed state=%0d init=%b seed=%h want 5/1/%h",
               bus.state, bus.shuffle_init, bus.seed, pre);
    end
    tick();
    tick();
    tick();
    total++;
    if (bus.state !== 3'd1) begin
      bad++;
      $display("FAIL shuffle_back_to_set state=%0d want 1", bus.state);
    end
  endtask

  initial begin
    test_reset();
    test_set_entry();
    test_confirm();
    test_shuffle();
    test_lockout();
    test_priority_open();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
